// File: rtl/score_bcd_conv_pkg.sv
// Shared types and constants for the score binary-to-BCD converter.
package score_bcd_conv_pkg;

    // Converter sequencing: wait for a request, run the dabble steps, present the result.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FIN   = 2'd2
    } state_t;

    localparam int unsigned NUM_DIGITS  = 4;
    localparam int unsigned DEF_BIN_W   = 14;
    localparam int unsigned DEF_MAX_VAL = 9999;

endpackage

// File: rtl/score_bcd_conv_bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD nibble that is 5 or more,
// so the following left shift carries correctly into the next decimal digit.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Correct one nibble; the 4-bit result never carries into a neighbour.
    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/score_bcd_conv.sv
// Sequential binary-to-BCD converter for the score display. A request clamps
// the input to MAX_VAL, then one double-dabble step runs per clock for BIN_W
// clocks; the four digits and overflow flag update together when it finishes.
module score_bcd_conv
    import score_bcd_conv_pkg::*;
#(
    parameter int unsigned BIN_W   = DEF_BIN_W,
    parameter int unsigned MAX_VAL = DEF_MAX_VAL
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [BIN_W-1:0] BIN,
    input  logic             START,
    output logic [3:0]       DOUT0,
    output logic [3:0]       DOUT1,
    output logic [3:0]       DOUT2,
    output logic [3:0]       DOUT3,
    output logic             BUSY,
    output logic             DONE,
    output logic             OVF
);

    localparam int unsigned ACC_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W);
    localparam logic [BIN_W-1:0] MAX_BIN  = BIN_W'(MAX_VAL);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    state_t             state;
    state_t             state_nxt;
    logic [BIN_W-1:0]   sr;
    logic [BIN_W-1:0]   sr_nxt;
    logic [BIN_W-1:0]   sr_step;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_nxt;
    logic [ACC_W-1:0]   acc_adj;
    logic [ACC_W-1:0]   acc_step;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               ovf_lat;
    logic               ovf_lat_nxt;
    logic               over;
    logic               load_out;

    // One correction unit per decimal digit of the accumulator.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        bcd_add3 u_add3 (
            .din  (acc[4*g +: 4]),
            .dout (acc_adj[4*g +: 4])
        );
    end

    // Combined {BCD, binary} left shift after correction.
    always_comb begin
        acc_step = {acc_adj[ACC_W-2:0], sr[BIN_W-1]};
        sr_step  = {sr[BIN_W-2:0], 1'b0};
    end

    assign over = (BIN > MAX_BIN);
    assign BUSY = (state != ST_IDLE);
    assign DONE = (state == ST_FIN);

    // Next-state and datapath control; everything holds unless a state acts on it.
    always_comb begin
        state_nxt   = state;
        sr_nxt      = sr;
        acc_nxt     = acc;
        cnt_nxt     = cnt;
        ovf_lat_nxt = ovf_lat;
        load_out    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    sr_nxt      = over ? MAX_BIN : BIN;
                    acc_nxt     = '0;
                    cnt_nxt     = '0;
                    ovf_lat_nxt = over;
                    state_nxt   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sr_nxt  = sr_step;
                acc_nxt = acc_step;
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == LAST_CNT) begin
                    cnt_nxt   = '0;
                    load_out  = 1'b1;
                    state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers; outputs load from the final step's
    // result on the same edge that ends the shift phase.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state   <= ST_IDLE;
            sr      <= '0;
            acc     <= '0;
            cnt     <= '0;
            ovf_lat <= 1'b0;
            DOUT0   <= '0;
            DOUT1   <= '0;
            DOUT2   <= '0;
            DOUT3   <= '0;
            OVF     <= 1'b0;
        end else begin
            state   <= state_nxt;
            sr      <= sr_nxt;
            acc     <= acc_nxt;
            cnt     <= cnt_nxt;
            ovf_lat <= ovf_lat_nxt;
            if (load_out) begin
                DOUT0 <= acc_step[3:0];
                DOUT1 <= acc_step[7:4];
                DOUT2 <= acc_step[11:8];
                DOUT3 <= acc_step[15:12];
                OVF   <= ovf_lat;
            end
        end
    end

endmodule

// File: tb/tb_score_bcd_conv.sv
// Directed bench for score_bcd_conv with hand-computed BCD results.
module tb_score_bcd_conv;

    logic        CLK   = 1'b0;
    logic        CLR   = 1'b0;
    logic        START = 1'b0;
    logic [13:0] BIN   = '0;
    logic [3:0]  DOUT0, DOUT1, DOUT2, DOUT3;
    logic        BUSY, DONE, OVF;

    int total = 0;
    int bad   = 0;

    logic [15:0] shown     = '0;
    logic        shown_ovf = 1'b0;

    always #5 CLK = ~CLK;

    score_bcd_conv #(
        .BIN_W   (14),
        .MAX_VAL (9999)
    ) dut (
        .CLK   (CLK),
        .CLR   (CLR),
        .BIN   (BIN),
        .START (START),
        .DOUT0 (DOUT0),
        .DOUT1 (DOUT1),
        .DOUT2 (DOUT2),
        .DOUT3 (DOUT3),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .OVF   (OVF)
    );

    function automatic logic [15:0] dout_all();
        return {DOUT3, DOUT2, DOUT1, DOUT0};
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        int e;
        e = (v > 9999) ? 9999 : v;
        return {4'(e / 1000), 4'((e / 100) % 10), 4'((e / 10) % 10), 4'(e % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_conv(input string name, input logic [13:0] b,
                            input logic [15:0] exp_bcd, input logic exp_ovf, input bit noise);
        int lat;
        bit hold_ok;
        @(negedge CLK);
        BIN   = b;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        check({name, "_accept"}, 32'(BUSY), 32'd1);
        lat     = 0;
        hold_ok = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            if (noise) begin
                START = (i == 3 || i == 15);
                if (START) BIN = 14'd1111;
            end
            if (DONE) begin
                lat = i;
                break;
            end
            if (!BUSY || dout_all() !== shown || OVF !== shown_ovf) hold_ok = 1'b0;
        end
        check({name, "_latency"}, 32'(lat), 32'd15);
        check({name, "_hold"}, 32'(hold_ok), 32'd1);
        check({name, "_dout"}, 32'(dout_all()), 32'(exp_bcd));
        check({name, "_ovf"}, 32'(OVF), 32'(exp_ovf));
        shown     = exp_bcd;
        shown_ovf = exp_ovf;
        @(posedge CLK);
        #1;
        START = 1'b0;
        @(negedge CLK);
        check({name, "_done_pulse"}, 32'(DONE), 32'd0);
        check({name, "_idle"}, 32'(BUSY), 32'd0);
    endtask

    task automatic watch_quiet(input string name);
        bit quiet;
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (DONE || BUSY) quiet = 1'b0;
        end
        check(name, 32'(quiet), 32'd1);
    endtask

    initial begin
        int vals[$];
        int lat;
        int maxnib;
        logic [15:0] got;

        // reset held from time zero
        #12;
        check("rst_dout", 32'(dout_all()), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_ovf", 32'(OVF), 32'd0);
        @(negedge CLK);
        CLR = 1'b1;

        run_conv("zero", 14'd0, 16'h0000, 1'b0, 1'b0);
        run_conv("v1234", 14'd1234, 16'h1234, 1'b0, 1'b0);
        run_conv("v9999", 14'd9999, 16'h9999, 1'b0, 1'b0);
        run_conv("v10", 14'd10, 16'h0010, 1'b0, 1'b0);
        run_conv("v12000", 14'd12000, 16'h9999, 1'b1, 1'b0);
        run_conv("v5", 14'd5, 16'h0005, 1'b0, 1'b0);
        run_conv("v4321", 14'd4321, 16'h4321, 1'b0, 1'b1);
        watch_quiet("no_queue");

        // abort a conversion with reset in its seventh cycle
        @(negedge CLK);
        BIN   = 14'd8765;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (6) @(negedge CLK);
        CLR = 1'b0;
        #1;
        check("abort_dout", 32'(dout_all()), 32'd0);
        check("abort_busy", 32'(BUSY), 32'd0);
        check("abort_done", 32'(DONE), 32'd0);
        check("abort_ovf", 32'(OVF), 32'd0);
        shown     = '0;
        shown_ovf = 1'b0;
        repeat (3) @(negedge CLK);
        CLR = 1'b1;
        watch_quiet("abort_no_done");
        run_conv("v42", 14'd42, 16'h0042, 1'b0, 1'b0);

        // back-to-back conversions with START held high
        for (int v = 0; v <= 20; v++) vals.push_back(v);
        for (int v = 9990; v <= 10010; v++) vals.push_back(v);
        for (int v = 16370; v <= 16383; v++) vals.push_back(v);
        for (int v = 21; v < 16384; v += 7) vals.push_back(v);
        maxnib = 0;
        @(negedge CLK);
        BIN   = 14'(vals[0]);
        START = 1'b1;
        for (int k = 0; k < vals.size(); k++) begin
            lat = 0;
            for (int i = 1; i <= 40; i++) begin
                @(negedge CLK);
                if (DONE) begin
                    lat = i;
                    break;
                end
            end
            check((k == 0) ? "stream_first_lat" : "stream_period", 32'(lat),
                  (k == 0) ? 32'd15 : 32'd16);
            got = dout_all();
            for (int d = 0; d < 4; d++) begin
                if (int'(got[4*d +: 4]) > maxnib) maxnib = int'(got[4*d +: 4]);
            end
            check("stream_dout", 32'(got), 32'(to_bcd(vals[k])));
            check("stream_ovf", 32'(OVF), (vals[k] > 9999) ? 32'd1 : 32'd0);
            if (k + 1 < vals.size()) BIN = 14'(vals[k + 1]);
        end
        START = 1'b0;
        check("stream_nibble_max", 32'(maxnib <= 9), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/score_bcd_conv.md
SCORE_BCD_CONV -- requirements
Module: score_bcd_conv

Interface
REQ-001 SHALL have parameter BIN_W, default 14, the width of the binary input (range 14..16).
REQ-002 SHALL have parameter MAX_VAL, default 9999, the largest displayable value; larger inputs saturate to it.
REQ-003 CLK  input  1  single system clock; all state updates on its rising edge.
REQ-004 CLR  input  1  reset, asynchronous, active-low.
REQ-005 BIN  input  BIN_W  unsigned binary score, sampled only when a START is accepted.
REQ-006 START  input  1  conversion request; one-cycle pulse or level.
REQ-007 DOUT0..DOUT3  output  4 each  BCD digits (DOUT0 = ones, DOUT3 = thousands); registered; feed the 7-segment scan driver's DIN0..DIN3.
REQ-008 BUSY  output  1  high while a conversion is in progress.
REQ-009 DONE  output  1  one-cycle pulse; DOUT0..DOUT3 and OVF are valid and newly updated.
REQ-010 OVF  output  1  registered; set when the last accepted BIN exceeded MAX_VAL.

Function
REQ-011 SHALL implement an FSM with states IDLE, SHIFT and FIN; the reset state is IDLE.
REQ-012 IDLE: START=1 at a rising edge SHALL be accepted. At that edge:
  - the clamped value min(BIN, MAX_VAL) loads into the shift register;
  - the BCD accumulator clears;
  - the bit counter clears;
  - the overflow flag (BIN>MAX_VAL) latches internally;
  - the state moves to SHIFT.
REQ-013 SHIFT SHALL take exactly BIN_W cycles, one double-dabble step per cycle:
  - first, every BCD nibble >= 5 gets +3;
  - then the combined {BCD, binary} register shifts left by 1, taking the binary MSB into BCD bit 0.
REQ-014 On the edge ending the final SHIFT cycle:
  - DOUT0..DOUT3 and OVF SHALL load simultaneously from the accumulator and the latched flag;
  - the state SHALL move to FIN.
REQ-015 FIN SHALL last one cycle with DONE=1, then return to IDLE unconditionally.
REQ-016 BUSY SHALL be 1 exactly in SHIFT and FIN, and 0 in IDLE.
REQ-017 Latency: START accepted at edge N gives DONE=1 in the cycle after edge N+BIN_W. With the default this is 15 cycles after acceptance. The next START is accepted at edge N+BIN_W+2 at the earliest.
REQ-018 START while BUSY=1 SHALL be ignored; it is not queued.
REQ-019 DOUT0..DOUT3 and OVF SHALL hold their previous values throughout SHIFT, so the display never shows partial results.
REQ-020 Every DOUT nibble SHALL be in the range 0..9 at all times.
REQ-021 The BCD accumulator is 16 bits; the +3 correction on a nibble SHALL NOT carry into the next nibble.
REQ-022 BIN changes after acceptance SHALL NOT affect the running conversion.

Reset
REQ-023 CLR=0 SHALL immediately, without a clock, force:
  - state IDLE;
  - DOUT0..DOUT3 = 0;
  - BUSY=0, DONE=0, OVF=0;
  - shift register, accumulator and counter = 0.
REQ-024 A reset asserted mid-conversion SHALL abort it; no DONE follows.
REQ-025 After CLR deasserts, the first START SHALL be accepted at the first rising edge at which it is high.

Structure
REQ-026 Shared package SHALL hold:
  - the FSM state type (IDLE, SHIFT, FIN);
  - the BCD digit count (4);
  - the default BIN_W and MAX_VAL constants.
REQ-027 Sub-module bcd_add3 (combinational: 4-bit in, 4-bit out, +3 when >= 5) SHALL be instantiated once per digit.
REQ-028 There SHALL be a single always-block FSM with an asynchronous active-low reset branch; no latches.

Verification
REQ-029 BIN=0, START pulse at edge 1 -> BUSY=1 for 15 cycles; DONE in the cycle after edge 15; DOUT3..0 = 0,0,0,0; OVF=0.
REQ-030 BIN=1234 -> DOUT3..0 = 1,2,3,4, OVF=0. Then BIN=9999 -> 9,9,9,9. Then BIN=10 -> 0,0,1,0.
REQ-031 BIN=12000 -> DOUT3..0 = 9,9,9,9 and OVF=1. A following conversion of BIN=5 -> 0,0,0,5 with OVF=0.
REQ-032 BIN=4321 accepted, then START pulses with BIN=1111 at cycles 3 and 15 -> only one DONE; result 4,3,2,1; DOUT stays at the prior value until the DONE edge.
REQ-033 CLR low at cycle 7 of a conversion of 8765 -> all outputs 0 immediately and no DONE. After release, a conversion of 42 -> 0,0,4,2.
REQ-034 Exhaustive 0..16383 with START held high continuously -> a conversion every 16 cycles; every result equals decimal min(BIN, 9999); every nibble <= 9.
